// File: rtl/clock_step_controller.sv
// Clock-enable generator for the CPU core: RUN, SLOW (divided tick), STEP (debounced button) and PAUSE.
// Optional breakpoint-to-step support is compiled in with `define CLK_STEP_BREAKPOINT_EN.
module clock_step_controller #(
  parameter int unsigned DIV_FACTOR      = 1_200_000,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode_sel,
  input  logic                  step_btn,
  input  logic                  halt_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] bp_addr_i,
  input  logic                  bp_valid_i,
  output logic                  cpu_clk_en,
  output logic [1:0]            mode_o,
  output logic                  heartbeat_o,
  output logic                  bp_hit_o,
  output logic [15:0]           en_count_o
);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SLOW  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_PAUSE = 2'b11;

  localparam int unsigned DIV_W = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_FACTOR - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       mode_q, mode_d;
  logic             en_q, en_d;
  logic             hb_q, hb_d;
  logic [15:0]      en_cnt_q, en_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_level_q, db_level_d;
  logic [DEB_W-1:0] db_cnt_q, db_cnt_d;
  logic             step_pend_q, step_pend_d;

  logic mode_chg;
  logic db_rise;
  logic div_wrap;
  logic stepping;
  logic bp_trig;
  logic en_raw;

`ifdef CLK_STEP_BREAKPOINT_EN
  logic bp_active_q, bp_active_d;
  logic bp_match_q, bp_match_d;
  logic bp_match;
`else
  logic unused_bp;
  assign unused_bp = ^{pc_i, bp_addr_i, bp_valid_i};
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    mode_d   = mode_sel;
    mode_chg = (mode_sel != mode_q);
    sync1_d  = step_btn;
    sync2_d  = sync1_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    db_rise    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DEB_LAST) begin
        db_level_d = sync2_q;
        db_rise    = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DEB_W'(1);
      end
    end

`ifdef CLK_STEP_BREAKPOINT_EN
    // Only a fresh match triggers, so stepping onto the same pc cannot re-arm the pause.
    bp_match    = bp_valid_i && (pc_i == bp_addr_i);
    bp_match_d  = bp_match;
    bp_trig     = bp_match && !bp_match_q && !bp_active_q && !mode_chg &&
                  ((mode_q == MODE_RUN) || (mode_q == MODE_SLOW));
    bp_active_d = bp_active_q;
    if (mode_chg || !bp_valid_i) begin
      bp_active_d = 1'b0;
    end else if (bp_trig) begin
      bp_active_d = 1'b1;
    end
    stepping = (mode_q == MODE_STEP) || bp_active_q;
`else
    bp_trig  = 1'b0;
    stepping = (mode_q == MODE_STEP);
`endif

    div_wrap = (div_cnt_q == DIV_LAST);
    if (mode_chg || (mode_q != MODE_SLOW) || div_wrap) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    en_raw = 1'b0;
    if (stepping) begin
      en_raw = step_pend_q;
    end else begin
      case (mode_q)
        MODE_RUN:   en_raw = 1'b1;
        MODE_SLOW:  en_raw = div_wrap;
        MODE_PAUSE: en_raw = 1'b0;
        default:    en_raw = 1'b0;
      endcase
    end

    en_d        = en_raw && !halt_i && !mode_chg && !bp_trig;
    // Presses outside a stepping mode are dropped rather than queued.
    step_pend_d = db_rise && stepping && !mode_chg;
    hb_d        = hb_q ^ en_d;
    en_cnt_d    = en_cnt_q + 16'(en_d);
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_PAUSE;
      en_q        <= 1'b0;
      hb_q        <= 1'b0;
      en_cnt_q    <= '0;
      div_cnt_q   <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_level_q  <= 1'b0;
      db_cnt_q    <= '0;
      step_pend_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      en_q        <= en_d;
      hb_q        <= hb_d;
      en_cnt_q    <= en_cnt_d;
      div_cnt_q   <= div_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      step_pend_q <= step_pend_d;
    end
  end

`ifdef CLK_STEP_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_active_q <= 1'b0;
      bp_match_q  <= 1'b0;
    end else begin
      bp_active_q <= bp_active_d;
      bp_match_q  <= bp_match_d;
    end
  end

  assign bp_hit_o = bp_active_q;
`else
  assign bp_hit_o = 1'b0;
`endif

  assign cpu_clk_en  = en_q;
  assign mode_o      = mode_q;
  assign heartbeat_o = hb_q;
  assign en_count_o  = en_cnt_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Bench for clock_step_controller (DIV_FACTOR=4, DEBOUNCE_CYCLES=3): vector table, directed
// step/pause/breakpoint sequences, then random stimulus against a behavioural model.
module tb_clock_step_controller;

  localparam int DIV = 4;
  localparam int DEB = 3;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode_sel;
  logic          step_btn;
  logic          halt_i;
  logic [AW-1:0] pc_i;
  logic [AW-1:0] bp_addr_i;
  logic          bp_valid_i;
  logic          cpu_clk_en;
  logic [1:0]    mode_o;
  logic          heartbeat_o;
  logic          bp_hit_o;
  logic [15:0]   en_count_o;

  always #5 clk = ~clk;

  clock_step_controller #(
    .DIV_FACTOR     (DIV),
    .DEBOUNCE_CYCLES(DEB),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_sel   (mode_sel),
    .step_btn   (step_btn),
    .halt_i     (halt_i),
    .pc_i       (pc_i),
    .bp_addr_i  (bp_addr_i),
    .bp_valid_i (bp_valid_i),
    .cpu_clk_en (cpu_clk_en),
    .mode_o     (mode_o),
    .heartbeat_o(heartbeat_o),
    .bp_hit_o   (bp_hit_o),
    .en_count_o (en_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: debounce as a window over the button history, slow mode as the
  // edge count since the last mode change taken modulo DIV.
  bit          hist[$];
  bit          m_level;
  logic [1:0]  m_mode;
  bit          m_en;
  bit          m_hb;
  bit          m_pend;
  logic [15:0] m_cnt;
  int          m_age;

  always @(posedge clk) begin : model
    int n;
    bit flip, rise, chg, en;
    if (reset) begin
      hist.delete();
      repeat (5) hist.push_back(1'b0);
      m_level = 1'b0;
      m_mode  = 2'b11;
      m_en    = 1'b0;
      m_hb    = 1'b0;
      m_pend  = 1'b0;
      m_cnt   = '0;
      m_age   = 0;
    end else begin
      hist.push_back(step_btn);
      if (hist.size() > 8) void'(hist.pop_front());
      n    = hist.size();
      // Synced value seen at this edge is the button sampled two edges earlier.
      flip = (hist[n-3] != m_level) && (hist[n-4] != m_level) && (hist[n-5] != m_level);
      rise = flip && !m_level;
      chg  = (mode_sel != m_mode);
      if (chg)                 en = 1'b0;
      else if (m_mode == 2'b00) en = 1'b1;
      else if (m_mode == 2'b01) en = ((m_age + 1) % DIV) == 0;
      else if (m_mode == 2'b10) en = m_pend;
      else                      en = 1'b0;
      if (halt_i) en = 1'b0;
      m_pend = rise && (m_mode == 2'b10) && !chg;
      m_age  = chg ? 0 : m_age + 1;
      m_mode = mode_sel;
      m_en   = en;
      if (en) begin
        m_hb  = !m_hb;
        m_cnt = m_cnt + 16'd1;
      end
      if (flip) m_level = !m_level;
    end
  end

  typedef struct {
    logic        rst;
    logic [1:0]  mode;
    logic        halt;
    logic        exp_en;
    logic [1:0]  exp_mode;
    logic [15:0] exp_cnt;
    logic        exp_hb;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [1:0] mode, input logic halt,
                              input logic exp_en, input logic [1:0] exp_mode,
                              input int exp_cnt);
    vec_t v;
    v.rst      = rst;
    v.mode     = mode;
    v.halt     = halt;
    v.exp_en   = exp_en;
    v.exp_mode = exp_mode;
    v.exp_cnt  = 16'(exp_cnt);
    v.exp_hb   = 1'(exp_cnt % 2);
    vecs.push_back(v);
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit btn_target;
    int en_seen;

    reset      = 1'b1;
    mode_sel   = 2'b00;
    step_btn   = 1'b0;
    halt_i     = 1'b0;
    pc_i       = '0;
    bp_addr_i  = '0;
    bp_valid_i = 1'b0;

    // Reset, RUN start-up, SLOW division, mid-count switch to RUN, halt.
    add(1, 2'b00, 0, 0, 2'b11, 0);
    add(1, 2'b00, 0, 0, 2'b11, 0);
    add(0, 2'b00, 0, 0, 2'b00, 0);
    for (int k = 1; k <= 10; k++) add(0, 2'b00, 0, 1, 2'b00, k);
    add(0, 2'b01, 0, 0, 2'b01, 10);
    for (int a = 1; a <= 10; a++) add(0, 2'b01, 0, (a % DIV) == 0, 2'b01, 10 + a / DIV);
    add(0, 2'b00, 0, 0, 2'b00, 12);
    for (int k = 13; k <= 15; k++) add(0, 2'b00, 0, 1, 2'b00, k);
    for (int h = 0; h < 8; h++) add(0, 2'b00, 1, 0, 2'b00, 15);
    add(0, 2'b00, 0, 1, 2'b00, 16);
    add(0, 2'b00, 0, 1, 2'b00, 17);

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      mode_sel = vecs[i].mode;
      halt_i   = vecs[i].halt;
      tick();
      check($sformatf("vec%0d_en", i),    32'(cpu_clk_en),  32'(vecs[i].exp_en));
      check($sformatf("vec%0d_mode", i),  32'(mode_o),      32'(vecs[i].exp_mode));
      check($sformatf("vec%0d_count", i), 32'(en_count_o),  32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_hb", i),    32'(heartbeat_o), 32'(vecs[i].exp_hb));
      check($sformatf("vec%0d_bp", i),    32'(bp_hit_o),    32'(0));
    end

    // STEP: bounce 1/0 then hold; enable lands 6 edges after the button is stably high.
    mode_sel = 2'b10;
    tick();
    tick();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("step1_en_c%0d", i), 32'(cpu_clk_en), 32'(i == 6));
    end
    check("step1_count", 32'(en_count_o), 32'd18);
    check("step1_hb", 32'(heartbeat_o), 32'd0);
    step_btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("release_en_c%0d", i), 32'(cpu_clk_en), 32'd0);
    end
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("step2_en_c%0d", i), 32'(cpu_clk_en), 32'(i == 6));
    end
    check("step2_count", 32'(en_count_o), 32'd19);

    // PAUSE: a press is discarded and not replayed on entering STEP.
    mode_sel = 2'b11;
    step_btn = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    check("pause_mode", 32'(mode_o), 32'd3);
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("pause_press_en_c%0d", i), 32'(cpu_clk_en), 32'd0);
    end
    mode_sel = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("no_queue_en_c%0d", i), 32'(cpu_clk_en), 32'd0);
    end
    step_btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("step_release_en_c%0d", i), 32'(cpu_clk_en), 32'd0);
    end
    check("pause_count", 32'(en_count_o), 32'd19);

`ifdef CLK_STEP_BREAKPOINT_EN
    // Breakpoint: RUN stops at pc match, one press steps once, dropping bp_valid resumes.
    mode_sel   = 2'b00;
    bp_addr_i  = 16'h0012;
    bp_valid_i = 1'b1;
    pc_i       = 16'h0000;
    tick();
    tick();
    tick();
    check("bp_run_en", 32'(cpu_clk_en), 32'd1);
    check("bp_run_count", 32'(en_count_o), 32'd21);
    pc_i = 16'h0012;
    tick();
    check("bp_hit_en", 32'(cpu_clk_en), 32'd0);
    check("bp_hit", 32'(bp_hit_o), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("bp_stopped_en_c%0d", i), 32'(cpu_clk_en), 32'd0);
    end
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("bp_step_en_c%0d", i), 32'(cpu_clk_en), 32'(i == 6));
    end
    check("bp_step_count", 32'(en_count_o), 32'd22);
    check("bp_still_hit", 32'(bp_hit_o), 32'd1);
    bp_valid_i = 1'b0;
    step_btn   = 1'b0;
    tick();
    check("bp_clear", 32'(bp_hit_o), 32'd0);
    tick();
    check("bp_resume_en", 32'(cpu_clk_en), 32'd1);
    bp_addr_i = '0;
    pc_i      = '0;
`endif

    // Random phase against the model.
    reset    = 1'b1;
    mode_sel = 2'b00;
    halt_i   = 1'b0;
    step_btn = 1'b0;
    tick();
    reset      = 1'b0;
    btn_target = 1'b0;
    en_seen    = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 23) == 0) mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) btn_target = !btn_target;
      step_btn = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : btn_target;
      if ($urandom_range(0, 29) == 0) halt_i = !halt_i;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      if (cpu_clk_en) en_seen++;
      check($sformatf("rnd%0d_en", i),    32'(cpu_clk_en),  32'(m_en));
      check($sformatf("rnd%0d_mode", i),  32'(mode_o),      32'(m_mode));
      check($sformatf("rnd%0d_hb", i),    32'(heartbeat_o), 32'(m_hb));
      check($sformatf("rnd%0d_count", i), 32'(en_count_o),  32'(m_cnt));
    end
    check("rnd_activity", 32'(en_seen > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
